// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt cause path: vector geometry, cause
// indices and the helper that decides whether jisr/il services one line.
package interrupt_pkg;

  localparam int CA_W = 23;
  localparam int IL_W = 5;

  // Cause indices inside ca[22:0]
  localparam int CA_RESET  = 0;
  localparam int CA_ILL    = 1;
  localparam int CA_MAL    = 2;
  localparam int CA_PFF    = 3;
  localparam int CA_PFLS   = 4;
  localparam int CA_TRAP   = 5;
  localparam int CA_OVF    = 6;
  localparam int CA_NMI    = 16;
  localparam int CA_BUSERR = 17;
  localparam int CA_EXT0   = 18;

  // Internal (pipeline) and external (line) ranges of the cause vector
  localparam int INT_LO = 0;
  localparam int INT_HI = 15;
  localparam int EXT_LO = 16;
  localparam int EXT_HI = 22;

  typedef logic [CA_W-1:0] ca_t;
  typedef logic [IL_W-1:0] il_t;

  // What the internal cause register does this cycle
  typedef enum logic [1:0] {
    INT_LOAD  = 2'd0,
    INT_HOLD  = 2'd1,
    INT_FLUSH = 2'd2
  } int_op_e;

  // True when the controller is taking the interrupt whose cause index is idx
  function automatic logic clr_hit(input logic jisr, input il_t il, input int unsigned idx);
    return jisr && (il == il_t'(idx));
  endfunction

endpackage

// File: rtl/irq_line_sync.sv
// One external request line: synchroniser chain, edge detector and the
// pending flop that feeds the cause vector. LEVEL selects level-following
// behaviour instead of the sticky edge latch. SYNC_STAGES must be >= 2.
module irq_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit LEVEL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic irq,
  output logic pend,
  output logic pend_next
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pend;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_pend_next;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;

  // Next pending value: level lines follow the synchronised input; edge
  // lines latch a rising edge and drop only when serviced. A new edge in the
  // same cycle as the clear wins so the event is not lost.
  always_comb begin
    w_pend_next = r_pend;
    if (LEVEL) begin
      w_pend_next = w_s;
    end else begin
      w_pend_next = w_rise | (r_pend & ~clr);
    end
  end

  // Synchroniser, edge history and pending state; all cleared by reset so a
  // line held high across reset release produces exactly one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq};
      r_prev <= w_s;
      r_pend <= w_pend_next;
    end
  end

  assign pend      = r_pend;
  assign pend_next = w_pend_next;

endmodule

// File: rtl/cause_collector.sv
// Builds the registered cause vector for the interrupt controller: the low
// bits capture pipeline exception strobes, the high bits hold synchronised
// external requests. jisr/il feedback flushes the internal causes and clears
// the serviced external bit.
module cause_collector
  import interrupt_pkg::*;
#(
  parameter int               N_INT       = 16,
  parameter int               N_EXT       = 7,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_EXT-1:0] LEVEL_MASK  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_INT-1:0]       int_cause,
  input  logic                   int_valid,
  input  logic                   stall,
  input  logic [N_EXT-1:0]       ext_irq,
  input  logic                   jisr,
  input  logic [IL_W-1:0]        il,
  output logic [N_INT+N_EXT-1:0] ca,
  output logic                   ext_pending
);

  logic [N_INT-1:0] r_int;
  logic             r_ext_pending;
  int_op_e          w_int_op;
  logic [N_EXT-1:0] w_clr;
  logic [N_EXT-1:0] w_pend;
  logic [N_EXT-1:0] w_pend_next;

  // Priority for the internal register: flush on jisr, then stall hold, else load
  always_comb begin
    w_int_op = INT_LOAD;
    if (jisr) begin
      w_int_op = INT_FLUSH;
    end else if (stall) begin
      w_int_op = INT_HOLD;
    end
  end

  // Internal cause register; bubbles (int_valid=0) load zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int <= '0;
    end else begin
      case (w_int_op)
        INT_FLUSH: r_int <= '0;
        INT_HOLD:  r_int <= r_int;
        default:   r_int <= int_valid ? int_cause : '0;
      endcase
    end
  end

  // One synchroniser/pending slice per external line
  generate
    for (genvar gi = 0; gi < N_EXT; gi++) begin : g_line
      assign w_clr[gi] = clr_hit(jisr, il, N_INT + gi);

      irq_line_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .LEVEL       (LEVEL_MASK[gi])
      ) u_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_clr[gi]),
        .irq       (ext_irq[gi]),
        .pend      (w_pend[gi]),
        .pend_next (w_pend_next[gi])
      );
    end
  endgenerate

  // Summary flag registered from the same next-state as the pending bits so
  // it changes in the same cycle as ca
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_pending <= 1'b0;
    end else begin
      r_ext_pending <= |w_pend_next;
    end
  end

  assign ca          = {w_pend, r_int};
  assign ext_pending = r_ext_pending;

endmodule

// File: tb/tb_cause_collector.sv
// Self-checking bench for cause_collector. The DUT is built with line 1
// level-sensitive (LEVEL_MASK=7'h02) so edge and level behaviour are both
// reachable; all other lines are edge-latched.
module tb_cause_collector;
  import interrupt_pkg::*;

  localparam int         SYNC = 2;
  localparam logic [6:0] LVL  = 7'h02;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] int_cause = '0;
  logic        int_valid = 1'b0;
  logic        stall = 1'b0;
  logic [6:0]  ext_irq = '0;
  logic        jisr = 1'b0;
  logic [4:0]  il = '0;
  logic [22:0] ca;
  logic        ext_pending;

  int total = 0;
  int bad   = 0;

  cause_collector #(
    .N_INT       (16),
    .N_EXT       (7),
    .SYNC_STAGES (SYNC),
    .LEVEL_MASK  (LVL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_cause   (int_cause),
    .int_valid   (int_valid),
    .stall       (stall),
    .ext_irq     (ext_irq),
    .jisr        (jisr),
    .il          (il),
    .ca          (ca),
    .ext_pending (ext_pending)
  );

  always #5 clk = ~clk;

  // Reference model: history of line samples taken at each clock edge; a line
  // reaches the pending bit SYNC edges after it was sampled.
  logic [6:0]  hq[$];
  logic [6:0]  m_pend = '0;
  logic [15:0] m_int  = '0;

  task automatic model_reset();
    hq.delete();
    m_pend = '0;
    m_int  = '0;
  endtask

  task automatic model_edge();
    logic [6:0] d;
    logic [6:0] dd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hq.push_back(ext_irq);
    d  = (hq.size() > SYNC)     ? hq[hq.size()-1-SYNC] : 7'h00;
    dd = (hq.size() > SYNC + 1) ? hq[hq.size()-2-SYNC] : 7'h00;
    for (int k = 0; k < 7; k++) begin
      if (LVL[k]) m_pend[k] = d[k];
      else        m_pend[k] = (d[k] & ~dd[k]) | (m_pend[k] & !(jisr && (int'(il) == 16 + k)));
    end
    if (hq.size() > 8) void'(hq.pop_front());
    if (jisr)        m_int = '0;
    else if (!stall) m_int = int_valid ? int_cause : 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  typedef struct {
    logic        v;
    logic [15:0] cause;
    logic        st;
    logic        j;
    logic [4:0]  il;
    logic [15:0] exp;
  } ivec_t;

  ivec_t tbl[14];

  initial begin
    // Internal path vectors: applied one per cycle, expected ca after the edge
    tbl[0]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 5'd0,  16'h0040};
    tbl[1]  = '{1'b0, 16'h0040, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[2]  = '{1'b0, 16'h0040, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[3]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 5'd0,  16'h0020};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0,  16'h0020};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0,  16'h0020};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0,  16'h0020};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0,  16'h0020};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[9]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 5'd0,  16'hFFFF};
    tbl[10] = '{1'b1, 16'h1234, 1'b1, 1'b1, 5'd5,  16'h0000};
    tbl[11] = '{1'b1, 16'h8001, 1'b0, 1'b0, 5'd0,  16'h8001};
    tbl[12] = '{1'b1, 16'h00FF, 1'b1, 1'b0, 5'd0,  16'h8001};
    tbl[13] = '{1'b1, 16'h00FF, 1'b0, 1'b0, 5'd0,  16'h00FF};

    // Reset with line 0 held high: exactly one event after release
    rst_n   = 1'b0;
    ext_irq = 7'h01;
    repeat (3) step();
    check("reset_ca", 32'(ca), 32'h0);
    check("reset_extp", 32'(ext_pending), 32'h0);
    rst_n = 1'b1;
    step();
    check("rel_c1", 32'(ca), 32'h0);
    step();
    check("rel_c2", 32'(ca), 32'h0);
    step();
    check("rel_c3", 32'(ca), 32'h010000);
    check("rel_c3_extp", 32'(ext_pending), 32'h1);
    step();
    check("rel_hold", 32'(ca), 32'h010000);
    ext_irq = 7'h00;
    repeat (3) step();
    check("rel_sticky", 32'(ca), 32'h010000);
    jisr = 1'b1; il = 5'd16;
    step();
    jisr = 1'b0;
    check("nmi_clr", 32'(ca), 32'h0);
    check("nmi_clr_extp", 32'(ext_pending), 32'h0);

    // Internal path table
    for (int i = 0; i < 14; i++) begin
      int_valid = tbl[i].v;
      int_cause = tbl[i].cause;
      stall     = tbl[i].st;
      jisr      = tbl[i].j;
      il        = tbl[i].il;
      step();
      check($sformatf("int_vec%0d", i), 32'(ca), {16'h0, tbl[i].exp});
    end
    int_valid = 1'b0; int_cause = '0; stall = 1'b0; jisr = 1'b0; il = '0;
    step();

    // Edge line 5: pulse, wrong-index jisr keeps it, matching jisr clears it
    ext_irq = 7'h20;
    step(); step();
    ext_irq = 7'h00;
    step();
    check("l5_set", 32'(ca), 32'h200000);
    jisr = 1'b1; il = 5'd20;
    step();
    check("l5_other_il", 32'(ca), 32'h200000);
    il = 5'd21;
    step();
    jisr = 1'b0;
    check("l5_clr", 32'(ca), 32'h0);

    // Edge line 2: a new rise in the clear cycle is kept
    ext_irq = 7'h04;
    step(); step();
    ext_irq = 7'h00;
    step();
    check("l2_set", 32'(ca), 32'h040000);
    repeat (3) step();
    ext_irq = 7'h04;
    step(); step();
    jisr = 1'b1; il = 5'd18;
    step();
    jisr = 1'b0;
    check("l2_set_beats_clr", 32'(ca), 32'h040000);
    ext_irq = 7'h00;
    repeat (3) step();
    jisr = 1'b1; il = 5'd18;
    step();
    jisr = 1'b0;
    check("l2_clr", 32'(ca), 32'h0);

    // Level line 1: follows the line, ignores jisr
    ext_irq = 7'h02;
    step(); step();
    check("lv_c2", 32'(ca), 32'h0);
    step();
    check("lv_c3", 32'(ca), 32'h020000);
    jisr = 1'b1; il = 5'd17;
    step();
    jisr = 1'b0;
    check("lv_jisr", 32'(ca), 32'h020000);
    ext_irq = 7'h00;
    step(); step();
    check("lv_drop_c2", 32'(ca), 32'h020000);
    step();
    check("lv_drop_c3", 32'(ca), 32'h0);
    check("lv_drop_extp", 32'(ext_pending), 32'h0);

    // Asynchronous reset in the middle of a cycle
    ext_irq = 7'h02; int_valid = 1'b1; int_cause = 16'h0003;
    repeat (4) step();
    check("pre_arst", 32'(ca), 32'h020003);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_ca", 32'(ca), 32'h0);
    check("arst_extp", 32'(ext_pending), 32'h0);
    step();
    rst_n = 1'b1; ext_irq = 7'h00; int_valid = 1'b0; int_cause = '0;
    repeat (4) step();
    check("post_arst", 32'(ca), 32'h0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int_valid = ($urandom_range(0, 3) != 0);
      int_cause = 16'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      jisr      = ($urandom_range(0, 4) == 0);
      il        = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 22));
      if ($urandom_range(0, 2) == 0) ext_irq = ext_irq ^ 7'(1 << $urandom_range(0, 6));
      step();
      check($sformatf("rnd%0d_ca", n), 32'(ca), {9'h0, m_pend, m_int});
      check($sformatf("rnd%0d_extp", n), 32'(ext_pending), 32'(|m_pend));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
